mem_responder: RTL and testbench

//  Responder end of the mem_intf read/write protocol: a 32x8 synchronous memory driven by the
//  mem_test-side write_mem/read_mem tasks. Samples read/write/addr/data_in on posedge clk,

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_array.sv | 54 +++++
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the mem_responder slice.
// Contents: default widths, op_e (the per-edge operation decoded from read/write),
// decode_op helper, and PAR_W (stored parity bits per word).
// Configuration macro: MEM_PARITY_EN adds one even-parity bit to every stored word.
package mem_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

`ifdef MEM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } op_e;

  function automatic op_e decode_op(input logic rd, input logic wr);
    case ({rd, wr})
      2'b10:   return RD;
      2'b01:   return WR;
      2'b11:   return ERR;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_array.sv
// Storage for mem_responder: 2**ADDR_W words, asynchronously cleared, one write
// port (sampled on posedge clk) and one combinational read port.
// Ports:
//   clk, rst_n  clock and asynchronous active-low clear of every word
//   we          write enable
//   waddr/wdata write address and data
//   raddr       read address
//   rdata       stored word at raddr; with MEM_PARITY_EN the MSB is the stored parity
// Configuration macro: MEM_PARITY_EN (adds stored even parity and the flip_parity debug task).
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [DATA_W+PAR_W-1:0]   rdata
);

  localparam int WORD_W = DATA_W + PAR_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] w_word;

`ifdef MEM_PARITY_EN
  assign w_word = {^wdata, wdata};
`else
  assign w_word = wdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= w_word;
    end
  end

  assign rdata = r_mem[raddr];

`ifdef MEM_PARITY_EN
  // Debug hook: corrupt the stored parity of one word so the checker can be exercised.
  task automatic flip_parity(input logic [ADDR_W-1:0] a);
    r_mem[a][DATA_W] <= ~r_mem[a][DATA_W];
  endtask
`endif

endmodule

// File: rtl/mem_responder.sv
// Responder end of the mem_intf read/write protocol: 32x8 synchronous memory with
// registered read data, saturating access/collision counters and last-op status.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   read, write     requests sampled at posedge (both set = collision)
//   addr, data_in   access address and write data
//   data_out        read data, registered on the sampling edge, held otherwise
//   rd_cnt, wr_cnt  completed reads / writes, saturating
//   err_cnt         collisions, saturating
//   last_op         op_e decoded at the most recent edge
//   parity_err      stored-parity mismatch on the last read (0 without MEM_PARITY_EN)
// Configuration macro: MEM_PARITY_EN.
//
// state | meaning
// IDLE  | no request at last edge, everything held
// RD    | read performed, data_out loaded, rd_cnt bumped
// WR    | write performed, wr_cnt bumped
// ERR   | read and write together, nothing performed, err_cnt bumped
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [1:0]        last_op,
  output logic              parity_err
);

  localparam int WORD_W = DATA_W + PAR_W;

  op_e               w_op;
  logic              w_we;
  logic [WORD_W-1:0] w_rdata;

  op_e               r_last_op;
  logic [DATA_W-1:0] r_data_out;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  assign w_op = decode_op(read, write);
  assign w_we = (w_op == WR);

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (addr),
    .wdata (data_in),
    .raddr (addr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_op  <= IDLE;
      r_data_out <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_last_op <= w_op;
      unique case (w_op)
        RD: begin
          r_data_out <= w_rdata[DATA_W-1:0];
          if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;
        end
        WR: begin
          if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 1'b1;
        end
        ERR: begin
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
    end else if (w_op == RD) begin
      r_parity_err <= w_rdata[DATA_W] ^ (^w_rdata[DATA_W-1:0]);
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // Unknown request lines at a sampling edge are an initiator bug, not a state.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown({read, write}))
        else $error("mem_responder: read/write unknown at sampling edge");
    end
  end

  assign data_out = r_data_out;
  assign rd_cnt   = r_rd_cnt;
  assign wr_cnt   = r_wr_cnt;
  assign err_cnt  = r_err_cnt;
  assign last_op  = r_last_op;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0, write = 1'b0;
  logic [4:0]  addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic [15:0] rd_cnt, wr_cnt, err_cnt;
  logic [1:0]  last_op;
  logic        parity_err;

  // Narrow-counter instance used only for saturation checks.
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [4:0]  s_addr = '0;
  logic [7:0]  s_data_in = '0;
  logic [7:0]  s_data_out;
  logic [1:0]  s_rd_cnt, s_wr_cnt, s_err_cnt;
  logic [1:0]  s_last_op;
  logic        s_parity_err;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of words plus integer counters.
  logic [7:0] mdl_mem [32];
  bit         mdl_flip [32];
  logic [7:0] exp_dout;
  int         exp_rd, exp_wr, exp_err;
  logic [1:0] exp_last;
  logic       exp_perr;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .err_cnt(err_cnt), .last_op(last_op), .parity_err(parity_err)
  );

  mem_responder #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .read(s_read), .write(s_write), .addr(s_addr),
    .data_in(s_data_in), .data_out(s_data_out), .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt),
    .err_cnt(s_err_cnt), .last_op(s_last_op), .parity_err(s_parity_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mdl_mem[i]  = 8'h00;
      mdl_flip[i] = 1'b0;
    end
    exp_dout = 8'h00; exp_rd = 0; exp_wr = 0; exp_err = 0;
    exp_last = 2'd0; exp_perr = 1'b0;
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, " data_out"},   {24'h0, data_out},      {24'h0, exp_dout});
    check({tag, " rd_cnt"},     {16'h0, rd_cnt},        exp_rd);
    check({tag, " wr_cnt"},     {16'h0, wr_cnt},        exp_wr);
    check({tag, " err_cnt"},    {16'h0, err_cnt},       exp_err);
    check({tag, " last_op"},    {30'h0, last_op},       {30'h0, exp_last});
    check({tag, " parity_err"}, {31'h0, parity_err},    {31'h0, exp_perr});
  endtask

  // One protocol edge: drive, clock, update the model from the protocol rules, compare.
  task automatic do_op(input logic rd, input logic wr, input logic [4:0] a,
                       input logic [7:0] d, input string tag);
    read = rd; write = wr; addr = a; data_in = d;
    @(posedge clk);
    #1;
    if (rd && !wr) begin
      exp_dout = mdl_mem[a];
      exp_perr = mdl_flip[a];
      exp_rd   = sat16(exp_rd + 1);
      exp_last = 2'd1;
    end else if (wr && !rd) begin
      mdl_mem[a]  = d;
      mdl_flip[a] = 1'b0;
      exp_wr   = sat16(exp_wr + 1);
      exp_last = 2'd2;
    end else if (rd && wr) begin
      exp_err  = sat16(exp_err + 1);
      exp_last = 2'd3;
    end else begin
      exp_last = 2'd0;
    end
    check_all(tag);
  endtask

  task automatic apply_reset();
    read = 0; write = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    // 1: reset state, then a write aborted by reset mid-cycle.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all("reset");
    read = 0; write = 1; addr = 5'd5; data_in = 8'hAA;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    write = 0;
    rst_n = 1'b1;
    model_reset();
    check_all("abort");
    do_op(1, 0, 5'd5, 8'h00, "abort_rd");
    check("abort_rd lit", {24'h0, data_out}, 32'h00);

    // 2: write then read same address.
    apply_reset();
    do_op(0, 1, 5'd5, 8'h3C, "wr5");
    do_op(1, 0, 5'd5, 8'h00, "rd5");
    check("t2 data", {24'h0, data_out}, 32'h3C);
    check("t2 wr_cnt", {16'h0, wr_cnt}, 32'd1);
    check("t2 rd_cnt", {16'h0, rd_cnt}, 32'd1);

    // 3: fill with addr*7, read back in reverse.
    for (int i = 0; i < 32; i++) begin
      logic [7:0] v;
      v = 8'(i * 7);
      do_op(0, 1, 5'(i), v, "fill");
    end
    for (int i = 31; i >= 0; i--) begin
      logic [7:0] v;
      v = 8'(i * 7);
      do_op(1, 0, 5'(i), 8'h00, "rev");
      check("rev lit", {24'h0, data_out}, {24'h0, v});
    end

    // 4: collision at addr 3.
    do_op(1, 1, 5'd3, 8'hFF, "coll");
    check("coll err_cnt", {16'h0, err_cnt}, 32'd1);
    check("coll last_op", {30'h0, last_op}, {30'h0, ERR});
    do_op(1, 0, 5'd3, 8'h00, "coll_rb");
    check("coll mem3", {24'h0, data_out}, 32'd21);

    // 5: read 0x55 then idle ten cycles.
    do_op(0, 1, 5'd12, 8'h55, "w55");
    do_op(1, 0, 5'd12, 8'h00, "r55");
    for (int i = 0; i < 10; i++) do_op(0, 0, 5'($urandom), 8'($urandom), "idle");
    check("idle data", {24'h0, data_out}, 32'h55);
    check("idle last_op", {30'h0, last_op}, {30'h0, IDLE});

    // Randomized traffic against the model, with a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      if (i == 200) apply_reset();
      do_op(op[1], op[0], 5'($urandom), 8'($urandom), "rand");
    end

`ifdef MEM_PARITY_EN
    // 6: parity corruption detected on read, cleared by the next clean read.
    do_op(0, 1, 5'd9, 8'h81, "pw");
    dut.u_array.flip_parity(5'd9);
    mdl_flip[9] = 1'b1;
    do_op(1, 0, 5'd9, 8'h00, "pr_bad");
    check("par data", {24'h0, data_out}, 32'h81);
    check("par err", {31'h0, parity_err}, 32'd1);
    do_op(0, 0, 5'd0, 8'h00, "p_hold");
    check("par hold", {31'h0, parity_err}, 32'd1);
    do_op(0, 1, 5'd10, 8'h42, "pw2");
    do_op(1, 0, 5'd10, 8'h00, "pr_ok");
    check("par clean", {31'h0, parity_err}, 32'd0);
`endif

    // Saturation on the 2-bit-counter instance (counters reset above, at i==200).
    for (int k = 1; k <= 5; k++) begin
      s_write = 1; s_read = 0; s_addr = 5'(k); s_data_in = 8'(k);
      @(posedge clk); #1;
      check("sat wr_cnt", {30'h0, s_wr_cnt}, (k > 3) ? 32'd3 : 32'(k));
    end
    for (int k = 1; k <= 5; k++) begin
      s_write = 1; s_read = 1;
      @(posedge clk); #1;
      check("sat err_cnt", {30'h0, s_err_cnt}, (k > 3) ? 32'd3 : 32'(k));
    end
    for (int k = 1; k <= 4; k++) begin
      s_write = 0; s_read = 1; s_addr = 5'd2;
      @(posedge clk); #1;
      check("sat rd_cnt", {30'h0, s_rd_cnt}, (k > 3) ? 32'd3 : 32'(k));
    end
    check("sat rd data", {24'h0, s_data_out}, 32'h02);
    s_read = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
